// File: rtl/maze_arb_pkg.sv
// Shared types and constants for the maze memory arbiter.
//   arb_state_t : access sequencer states
//   req_id_t    : requester identity (solver / loader)
//   COORD_W_DEF : default coordinate width
//   STAT_W      : width of the optional statistics counters
//   LAT_W       : width of the read-latency down-counter (RD_LAT up to 7)
//   sat_inc     : saturating increment used by the statistics counters
package maze_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    ACK   = 2'd3
  } arb_state_t;

  typedef enum logic {
    REQ_S = 1'b0,
    REQ_L = 1'b1
  } req_id_t;

  localparam int COORD_W_DEF = 4;
  localparam int STAT_W      = 16;
  localparam int LAT_W       = 3;

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (v == '1) ? v : v + STAT_W'(1);
  endfunction

endpackage

// File: rtl/maze_rr_picker.sv
// Combinational 2-way round-robin picker with loader lock.
// Ports:
//   req_s, req_l : pending requests from solver / loader
//   last_gnt     : requester served most recently
//   lock_owned   : loader holds exclusive ownership (solver never picked)
//   winner       : selected requester
//   valid        : a requester was selected this cycle
module maze_rr_picker
  import maze_arb_pkg::*;
(
  input  logic    req_s,
  input  logic    req_l,
  input  req_id_t last_gnt,
  input  logic    lock_owned,
  output req_id_t winner,
  output logic    valid
);

  always_comb begin
    winner = REQ_S;
    valid  = 1'b0;
    if (lock_owned) begin
      winner = REQ_L;
      valid  = req_l;
    end else if (req_s && req_l) begin
      // on a tie, the requester not served last goes first
      winner = (last_gnt == REQ_S) ? REQ_L : REQ_S;
      valid  = 1'b1;
    end else if (req_l) begin
      winner = REQ_L;
      valid  = 1'b1;
    end else if (req_s) begin
      winner = REQ_S;
      valid  = 1'b1;
    end
  end

endmodule

// File: rtl/maze_mem_arbiter.sv
// Arbiter sharing the single 16x16 maze memory between the solver (S) and
// the loader (L). Each access is sequenced IDLE -> ISSUE -> (WAIT) -> ACK.
// Ports:
//   clk, rst_n                : clock, async active-low reset
//   req_/we_/x_/y_/wdata_{s,l} : requester access (held until ack)
//   lock_l                    : loader exclusive ownership request
//   ack_{s,l}, rdata_{s,l}    : completion pulse and read data
//   mem_x/mem_y/mem_rd/mem_wr/mem_din/mem_dout : memory port
//   busy                      : sequencer not in IDLE
// Optional build macro MAZE_ARB_STATS_EN adds saturating counters
//   gnt_cnt_s, gnt_cnt_l, conflict_cnt.
//
// state | meaning
// IDLE  | pick a winner, latch its request
// ISSUE | drive address/data and one read or write strobe
// WAIT  | read latency, capture mem_dout in the last cycle
// ACK   | one-cycle ack to the winner, remember it as last grant
module maze_mem_arbiter
  import maze_arb_pkg::*;
#(
  parameter int COORD_W = COORD_W_DEF,
  parameter int DATA_W  = 1,
  parameter int RD_LAT  = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_s,
  input  logic               we_s,
  input  logic [COORD_W-1:0] x_s,
  input  logic [COORD_W-1:0] y_s,
  input  logic [DATA_W-1:0]  wdata_s,
  input  logic               req_l,
  input  logic               we_l,
  input  logic [COORD_W-1:0] x_l,
  input  logic [COORD_W-1:0] y_l,
  input  logic [DATA_W-1:0]  wdata_l,
  input  logic               lock_l,
  output logic               ack_s,
  output logic               ack_l,
  output logic [DATA_W-1:0]  rdata_s,
  output logic [DATA_W-1:0]  rdata_l,
  output logic [COORD_W-1:0] mem_x,
  output logic [COORD_W-1:0] mem_y,
  output logic               mem_rd,
  output logic               mem_wr,
  output logic [DATA_W-1:0]  mem_din,
  input  logic [DATA_W-1:0]  mem_dout,
  output logic               busy
`ifdef MAZE_ARB_STATS_EN
  ,
  output logic [STAT_W-1:0]  gnt_cnt_s,
  output logic [STAT_W-1:0]  gnt_cnt_l,
  output logic [STAT_W-1:0]  conflict_cnt
`endif
);

  arb_state_t         state, state_nxt;
  req_id_t            last_gnt, gnt, pick_w;
  logic               pick_v;
  logic               lock_owned, lock_eff;
  logic               lat_we;
  logic [COORD_W-1:0] lat_x, lat_y;
  logic [DATA_W-1:0]  lat_wdata;
  logic [LAT_W-1:0]   wait_cnt;

  // ownership only blocks S while lock_l is still high; dropping lock_l
  // releases S in the very IDLE cycle that sees it low
  assign lock_eff = lock_owned & lock_l;

  maze_rr_picker u_picker (
    .req_s      (req_s),
    .req_l      (req_l),
    .last_gnt   (last_gnt),
    .lock_owned (lock_eff),
    .winner     (pick_w),
    .valid      (pick_v)
  );

  assign mem_x   = lat_x;
  assign mem_y   = lat_y;
  assign mem_din = lat_wdata;

  always_comb begin
    state_nxt = state;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    ack_s     = 1'b0;
    ack_l     = 1'b0;
    busy      = (state != IDLE);
    case (state)
      IDLE:  if (pick_v) state_nxt = ISSUE;
      ISSUE: begin
        mem_wr    = lat_we;
        mem_rd    = ~lat_we;
        state_nxt = lat_we ? ACK : WAIT;
      end
      WAIT:  if (wait_cnt == '0) state_nxt = ACK;
      ACK: begin
        ack_s     = (gnt == REQ_S);
        ack_l     = (gnt == REQ_L);
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_gnt   <= REQ_L;
      gnt        <= REQ_S;
      lock_owned <= 1'b0;
      lat_we     <= 1'b0;
      lat_x      <= '0;
      lat_y      <= '0;
      lat_wdata  <= '0;
      wait_cnt   <= '0;
      rdata_s    <= '0;
      rdata_l    <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (!lock_l)
            lock_owned <= 1'b0;
          else if (pick_v && pick_w == REQ_L)
            lock_owned <= 1'b1;
          if (pick_v) begin
            gnt       <= pick_w;
            lat_we    <= (pick_w == REQ_L) ? we_l    : we_s;
            lat_x     <= (pick_w == REQ_L) ? x_l     : x_s;
            lat_y     <= (pick_w == REQ_L) ? y_l     : y_s;
            lat_wdata <= (pick_w == REQ_L) ? wdata_l : wdata_s;
          end
        end
        ISSUE: wait_cnt <= LAT_W'(RD_LAT - 1);
        WAIT: begin
          if (wait_cnt == '0) begin
            if (gnt == REQ_S) rdata_s <= mem_dout;
            else              rdata_l <= mem_dout;
          end else begin
            wait_cnt <= wait_cnt - LAT_W'(1);
          end
        end
        ACK: last_gnt <= gnt;
        default: ;
      endcase
    end
  end

`ifdef MAZE_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_cnt_s    <= '0;
      gnt_cnt_l    <= '0;
      conflict_cnt <= '0;
    end else begin
      if (state == ACK && gnt == REQ_S) gnt_cnt_s <= sat_inc(gnt_cnt_s);
      if (state == ACK && gnt == REQ_L) gnt_cnt_l <= sat_inc(gnt_cnt_l);
      // a tie, or S held off by the loader lock
      if (state == IDLE && req_s && (req_l || lock_eff))
        conflict_cnt <= sat_inc(conflict_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_maze_mem_arbiter.sv
// Self-checking bench for maze_mem_arbiter: directed scenarios followed by
// randomized traffic, all checked against a transaction-level model that
// predicts grant order, strobe/ack timing and read data from a reference
// copy of the maze memory.
module tb_maze_mem_arbiter;
  import maze_arb_pkg::*;

  localparam int COORD_W = 4;
  localparam int DATA_W  = 1;
  localparam int RD_LAT  = 1;
  localparam int NCELL   = 1 << (2 * COORD_W);

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic req_s = 1'b0, req_l = 1'b0, we_s = 1'b0, we_l = 1'b0, lock_l = 1'b0;
  logic [COORD_W-1:0] x_s = '0, y_s = '0, x_l = '0, y_l = '0;
  logic [DATA_W-1:0]  wdata_s = '0, wdata_l = '0;
  logic ack_s, ack_l, mem_rd, mem_wr, busy;
  logic [DATA_W-1:0]  rdata_s, rdata_l, mem_din, mem_dout;
  logic [COORD_W-1:0] mem_x, mem_y;
`ifdef MAZE_ARB_STATS_EN
  logic [STAT_W-1:0] gnt_cnt_s, gnt_cnt_l, conflict_cnt;
`endif

  always #5 clk = ~clk;

  maze_mem_arbiter #(.COORD_W(COORD_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_s(req_s), .we_s(we_s), .x_s(x_s), .y_s(y_s), .wdata_s(wdata_s),
    .req_l(req_l), .we_l(we_l), .x_l(x_l), .y_l(y_l), .wdata_l(wdata_l),
    .lock_l(lock_l),
    .ack_s(ack_s), .ack_l(ack_l), .rdata_s(rdata_s), .rdata_l(rdata_l),
    .mem_x(mem_x), .mem_y(mem_y), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_din(mem_din), .mem_dout(mem_dout), .busy(busy)
`ifdef MAZE_ARB_STATS_EN
    , .gnt_cnt_s(gnt_cnt_s), .gnt_cnt_l(gnt_cnt_l), .conflict_cnt(conflict_cnt)
`endif
  );

  // memory with RD_LAT-cycle read pipeline; idle slots carry random bits so
  // a capture in the wrong cycle is visible
  logic [DATA_W-1:0] ref_mem [NCELL];
  logic [DATA_W-1:0] bmem    [NCELL];
  logic [DATA_W-1:0] pipe    [RD_LAT];
  logic init_req = 1'b0;

  always @(posedge clk) begin
    if (init_req) begin
      for (int i = 0; i < NCELL; i++) bmem[i] <= ref_mem[i];
    end else if (mem_wr) begin
      bmem[{mem_x, mem_y}] <= mem_din;
    end
    pipe[0] <= mem_rd ? bmem[{mem_x, mem_y}] : DATA_W'($urandom);
    for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign mem_dout = pipe[RD_LAT-1];

  // model state
  int cyc = 0;
  int m_g = -10, m_ack = -10;
  req_id_t m_w = REQ_S, m_last = REQ_L;
  logic m_lock = 1'b0, m_we = 1'b0;
  logic [COORD_W-1:0] m_x = '0, m_y = '0;
  logic [DATA_W-1:0]  m_d = '0, m_rdv = '0, m_rd_s = '0, m_rd_l = '0;
  logic pend_s = 1'b0, pend_l = 1'b0, gr_s = 1'b0, gr_l = 1'b0;
  int n_ack_s = 0, n_ack_l = 0, cyc_ack_s = -100, cyc_ack_l = -100;
  int n_checks = 0, n_fail = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic req_of(input req_id_t id);
    return (id == REQ_S) ? (req_s && !m_lock) : req_l;
  endfunction

  task automatic model_reset();
    m_g = -10; m_ack = -10; m_last = REQ_L; m_lock = 1'b0; m_we = 1'b0;
    m_rd_s = '0; m_rd_l = '0;
    pend_s = 1'b0; pend_l = 1'b0; gr_s = 1'b0; gr_l = 1'b0;
    req_s = 1'b0; req_l = 1'b0; lock_l = 1'b0;
  endtask

  // arbitration decision for the current cycle, if the arbiter is free
  task automatic decide();
    req_id_t pref, other, w;
    logic v;
    if (!rst_n || cyc <= m_ack) return;
    if (!lock_l) m_lock = 1'b0;
    pref  = (m_last == REQ_L) ? REQ_S : REQ_L;
    other = (pref == REQ_S) ? REQ_L : REQ_S;
    v = 1'b1;
    if (req_of(pref))       w = pref;
    else if (req_of(other)) w = other;
    else begin w = REQ_S; v = 1'b0; end
    if (!v) return;
    if (w == REQ_L && lock_l) m_lock = 1'b1;
    m_g = cyc; m_w = w;
    m_we = (w == REQ_S) ? we_s : we_l;
    m_x  = (w == REQ_S) ? x_s : x_l;
    m_y  = (w == REQ_S) ? y_s : y_l;
    m_d  = (w == REQ_S) ? wdata_s : wdata_l;
    m_ack = cyc + (m_we ? 2 : 2 + RD_LAT);
    if (m_we) ref_mem[{m_x, m_y}] = m_d;
    else      m_rdv = ref_mem[{m_x, m_y}];
    if (w == REQ_S) gr_s = 1'b1; else gr_l = 1'b1;
  endtask

  task automatic check_cycle();
    logic issue;
    issue = (cyc == m_g + 1);
    check_val("busy",   32'(busy),   32'(cyc > m_g && cyc <= m_ack));
    check_val("mem_rd", 32'(mem_rd), 32'(issue && !m_we));
    check_val("mem_wr", 32'(mem_wr), 32'(issue && m_we));
    if (issue) begin
      check_val("mem_x", 32'(mem_x), 32'(m_x));
      check_val("mem_y", 32'(mem_y), 32'(m_y));
      if (m_we) check_val("mem_din", 32'(mem_din), 32'(m_d));
    end
    check_val("ack_s", 32'(ack_s), 32'(cyc == m_ack && m_w == REQ_S));
    check_val("ack_l", 32'(ack_l), 32'(cyc == m_ack && m_w == REQ_L));
    if (ack_s) begin n_ack_s++; cyc_ack_s = cyc; end
    if (ack_l) begin n_ack_l++; cyc_ack_l = cyc; end
    if (cyc == m_ack) begin
      if (!m_we) begin
        if (m_w == REQ_S) m_rd_s = m_rdv; else m_rd_l = m_rdv;
      end
      m_last = m_w;
      if (m_w == REQ_S) begin pend_s = 1'b0; gr_s = 1'b0; req_s = 1'b0; end
      else              begin pend_l = 1'b0; gr_l = 1'b0; req_l = 1'b0; end
    end
    check_val("rdata_s", 32'(rdata_s), 32'(m_rd_s));
    check_val("rdata_l", 32'(rdata_l), 32'(m_rd_l));
  endtask

  task automatic tick();
    decide();
    @(posedge clk);
    #1;
    cyc++;
    check_cycle();
  endtask

  task automatic post(input req_id_t id, input logic we, input logic [COORD_W-1:0] x,
                      input logic [COORD_W-1:0] y, input logic [DATA_W-1:0] d);
    if (id == REQ_S) begin pend_s = 1'b1; req_s = 1'b1; we_s = we; x_s = x; y_s = y; wdata_s = d; end
    else             begin pend_l = 1'b1; req_l = 1'b1; we_l = we; x_l = x; y_l = y; wdata_l = d; end
  endtask

  task automatic run_idle(input int budget);
    int i;
    i = 0;
    while ((pend_s || pend_l || cyc <= m_ack) && i < budget) begin tick(); i++; end
    if (i >= budget) check_val("idle_timeout", {30'b0, pend_s, pend_l}, 32'd0);
  endtask

  task automatic wait_ack(input req_id_t id, input int budget);
    int n0, i;
    n0 = (id == REQ_S) ? n_ack_s : n_ack_l;
    i = 0;
    while (((id == REQ_S) ? n_ack_s : n_ack_l) == n0 && i < budget) begin tick(); i++; end
    if (i >= budget) check_val("ack_timeout", 32'((id == REQ_S) ? n_ack_s : n_ack_l), 32'(n0 + 1));
  endtask

  task automatic rand_step();
    if (!pend_s && $urandom_range(0, 2) == 0)
      post(REQ_S, 1'($urandom), COORD_W'($urandom), COORD_W'($urandom), DATA_W'($urandom));
    else if (gr_s) begin
      if ($urandom_range(0, 15) == 0) req_s = 1'b0;
      if ($urandom_range(0, 3) == 0) begin
        we_s = 1'($urandom); x_s = COORD_W'($urandom); y_s = COORD_W'($urandom); wdata_s = DATA_W'($urandom);
      end
    end
    if (!pend_l && $urandom_range(0, 2) == 0)
      post(REQ_L, 1'($urandom), COORD_W'($urandom), COORD_W'($urandom), DATA_W'($urandom));
    else if (gr_l) begin
      if ($urandom_range(0, 15) == 0) req_l = 1'b0;
      if ($urandom_range(0, 3) == 0) begin
        we_l = 1'($urandom); x_l = COORD_W'($urandom); y_l = COORD_W'($urandom); wdata_l = DATA_W'($urandom);
      end
    end
    if ($urandom_range(0, 9) == 0) lock_l = ~lock_l;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int s0, ns, nl, l2;
    for (int i = 0; i < NCELL; i++) ref_mem[i] = DATA_W'($urandom);
    ref_mem[{4'd3, 4'd5}] = 1'b1;
    model_reset();
    init_req = 1'b1;
    rst_n = 1'b0;
    repeat (3) tick();
    check_val("rst_mem_x", 32'(mem_x), 32'd0);
    check_val("rst_mem_y", 32'(mem_y), 32'd0);
    check_val("rst_mem_din", 32'(mem_din), 32'd0);
    init_req = 1'b0;
    rst_n = 1'b1;
    tick();

    // simultaneous writes right after reset: S first, L three cycles later
    post(REQ_S, 1'b1, 4'd1, 4'd2, 1'b1);
    post(REQ_L, 1'b1, 4'd3, 4'd4, 1'b0);
    run_idle(20);
    check_val("t2_order", 32'(cyc_ack_s < cyc_ack_l), 32'd1);
    check_val("t2_gap", 32'(cyc_ack_l - cyc_ack_s), 32'd3);

    // lone S read of (3,5) holding 1
    s0 = cyc; nl = n_ack_l;
    post(REQ_S, 1'b0, 4'd3, 4'd5, 1'b0);
    run_idle(20);
    check_val("t1_lat", 32'(cyc_ack_s - s0), 32'(2 + RD_LAT));
    check_val("t1_rdata", 32'(rdata_s), 32'd1);
    check_val("t1_no_ack_l", 32'(n_ack_l), 32'(nl));

    // locked loader burst with S requesting throughout
    ns = n_ack_s;
    lock_l = 1'b1;
    post(REQ_L, 1'b1, 4'd15, 4'd15, 1'b1);
    post(REQ_S, 1'b1, 4'd7, 4'd7, 1'b0);
    wait_ack(REQ_L, 20);
    post(REQ_L, 1'b1, 4'd0, 4'd0, 1'b1);
    wait_ack(REQ_L, 20);
    l2 = cyc;
    check_val("t3_s_blocked", 32'(n_ack_s), 32'(ns));
    lock_l = 1'b0;
    run_idle(20);
    check_val("t3_s_after", 32'(cyc_ack_s - l2), 32'd3);

    // reset asserted during WAIT
    post(REQ_S, 1'b0, 4'd9, 4'd9, 1'b0);
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_ack_s", 32'(ack_s), 32'd0);
    check_val("rst_ack_l", 32'(ack_l), 32'd0);
    check_val("rst_rdata_s", 32'(rdata_s), 32'd0);
    model_reset();
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    ns = n_ack_s; s0 = cyc;
    post(REQ_S, 1'b1, 4'd2, 4'd2, 1'b1);
    run_idle(20);
    check_val("t4_acks", 32'(n_ack_s - ns), 32'd1);
    check_val("t4_lat", 32'(cyc_ack_s - s0), 32'd2);

    // req_s dropped during ISSUE
    ns = n_ack_s;
    post(REQ_S, 1'b1, 4'd6, 4'd6, 1'b1);
    tick();
    req_s = 1'b0;
    run_idle(20);
    check_val("t5_acks", 32'(n_ack_s - ns), 32'd1);
    check_val("t5_busy", 32'(busy), 32'd0);

    // randomized traffic
    repeat (3000) begin
      rand_step();
      tick();
    end
    lock_l = 1'b0;
    run_idle(200);

`ifdef MAZE_ARB_STATS_EN
    rst_n = 1'b0;
    model_reset();
    tick();
    rst_n = 1'b1;
    tick();
    for (int r = 0; r < 4; r++) begin
      post(REQ_S, 1'b1, COORD_W'(r), 4'd1, 1'b1);
      post(REQ_L, 1'b1, COORD_W'(r), 4'd2, 1'b0);
      run_idle(30);
    end
    check_val("gnt_cnt_s", 32'(gnt_cnt_s), 32'd4);
    check_val("gnt_cnt_l", 32'(gnt_cnt_l), 32'd4);
    check_val("conflict_cnt", 32'(conflict_cnt), 32'd4);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/maze_mem_arbiter.md
Name: maze_mem_arbiter

Overview:
Shares the single 16x16 1-bit maze memory between two requesters: the solver (S, the rat controller/datapath) and the loader (L, host-side maze fill and readback). It arbitrates with 2-way round-robin, supports a loader lock for burst loads, and sequences each access through issue, read-latency wait and acknowledge. It sits between both requesters and the maze memory instance in the top level.

Parameters:
COORD_W, 4, width of each X/Y coordinate
DATA_W, 1, maze cell width
RD_LAT, 1, memory read latency in cycles (legal 1..7)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
req_s / req_l  in  1  access request; held until ack
we_s / we_l  in  1  1 = write, 0 = read
x_s, y_s / x_l, y_l  in  COORD_W  cell coordinate
wdata_s / wdata_l  in  DATA_W  write data
lock_l  in  1  loader keeps exclusive ownership while high
ack_s / ack_l  out  1  one-cycle completion pulse
rdata_s / rdata_l  out  DATA_W  read data, valid when ack is high
mem_x, mem_y  out  COORD_W  memory address
mem_rd, mem_wr  out  1  memory strobes
mem_din  out  DATA_W  memory write data
mem_dout  in  DATA_W  memory read data
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0; last_gnt=L, so S wins the first tie; lock ownership cleared.
- States:
  - IDLE: if any req, pick a winner, latch its we/x/y/wdata, and go to ISSUE. With no req, stay in IDLE.
  - ISSUE: one cycle. Drive mem_x/mem_y/mem_din from the latched values; assert mem_wr=we or mem_rd=~we. Next state is ACK for a write, WAIT for a read.
  - WAIT: lasts exactly RD_LAT cycles. Capture mem_dout into the winner's rdata register in the last WAIT cycle. Then go to ACK.
  - ACK: pulse the winner's ack for one cycle; rdata holds the captured value. Update last_gnt to the winner. Return to IDLE.
- Latency from req sampled in IDLE to ack: 2 cycles for a write, 2+RD_LAT cycles for a read. Minimum spacing between back-to-back grants is 3 cycles (IDLE, ISSUE, ACK).
- Arbitration:
  - If only one requester is active, it wins.
  - If both are active, the one not equal to last_gnt wins.
  - If lock_l=1 while L is the winner, L becomes owner. While owned, S is never granted, even if L's req is low. Ownership clears in IDLE once lock_l=0.
  - lock_l has no effect while S is mid-access; it is honoured at the next IDLE decision.
- Only the winner sees ack. The loser keeps req high and is served next.
- If req drops before ack (protocol violation): the access still completes and ack still pulses. There is no abort.
- Requester inputs change mid-access: ignored, because values are latched in IDLE.
- rdata_x is updated only by reads from that requester and holds otherwise.
- mem_rd and mem_wr are never high in the same cycle and are only high in ISSUE.

Optional Feature:
MAZE_ARB_STATS_EN
- With the macro defined: adds outputs gnt_cnt_s, gnt_cnt_l and conflict_cnt, each 16 bits and saturating at 0xFFFF.
  - gnt_cnt_x increments in the ACK state for that requester.
  - conflict_cnt increments in each IDLE decision cycle where both req are high or S is blocked by the lock.
  - All three reset to 0.
- Without the macro: the ports and counters are absent, and behaviour is otherwise identical.

Decomposition:
- Package maze_arb_pkg holds:
  - arb_state_t enum: IDLE, ISSUE, WAIT, ACK
  - req_id_t enum: REQ_S=0, REQ_L=1
  - COORD_W_DEF=4 and STAT_W=16
- Sub-module maze_rr_picker: combinational 2-way round-robin with lock. Inputs are req_s, req_l, last_gnt, lock_owned; outputs are winner and valid.

Test Plan:
- S read of (3,5), memory holding 1, RD_LAT=1 -> mem_rd high in cycle 1, ack_s in cycle 3, rdata_s=1; L idle and ack_l=0 throughout.
- S and L both request in the same cycle right after reset -> S granted first and L second; ack_s and ack_l pulses are 3 cycles apart for writes.
- L write bursts of (15,15)=1 and then (0,0)=1 with lock_l=1, S requesting continuously -> both L acks arrive before ack_s. After lock_l=0, S is served at the next IDLE.
- rst_n pulled low during WAIT -> busy=0 and acks=0 immediately. After release, the first access is taken from a fresh IDLE with no stale ack.
- req_s dropped during ISSUE -> ack_s still pulses once and busy returns to 0.
- With MAZE_ARB_STATS_EN defined: 4 simultaneous-request rounds -> gnt_cnt_s=4, gnt_cnt_l=4, conflict_cnt=4.
